// File: rtl/id_ex_pkg.sv
// Shared ALU NOP encodings, default widths and the ID->EX payload type.
package id_ex_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned ALUOP_W_DEF  = 8;
  localparam int unsigned ALUSEL_W_DEF = 3;

  localparam logic [ALUSEL_W_DEF-1:0] ALU_SEL_NOP = 3'b000;
  localparam logic [ALUOP_W_DEF-1:0]  ALU_NOP     = 8'h00;

  typedef struct packed {
    logic [ALUSEL_W_DEF-1:0] alusel;
    logic [ALUOP_W_DEF-1:0]  aluop;
    logic [DATA_W_DEF-1:0]   reg1;
    logic [DATA_W_DEF-1:0]   reg2;
    logic [DATA_W_DEF-1:0]   pc;
    logic [ADDR_W_DEF-1:0]   waddr;
    logic                    wen;
  } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: registered valid/ready on both sides, flush empties it.
module pipe_skid_buf #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept_in;

  assign accept_in = in_valid & in_ready_q;

  // Main register feeds the output; skid catches the one entry accepted after out_ready drops.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_in) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (out_ready) begin
          if (accept_in) main_d = in_data;
          else           state_d = EMPTY;
        end else if (accept_in) begin
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= RST_VAL;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage around a skid buffer; define ID_EX_PERF_CNT_EN for stall/bubble counters.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ALUOP_W  = ALUOP_W_DEF,
  parameter int unsigned ALUSEL_W = ALUSEL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUSEL_W-1:0] in_alusel,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic [DATA_W-1:0]   in_reg1,
  input  logic [DATA_W-1:0]   in_reg2,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [ADDR_W-1:0]   in_reg_write_addr,
  input  logic                in_reg_write_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUSEL_W-1:0] out_alusel,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic [DATA_W-1:0]   out_reg1,
  output logic [DATA_W-1:0]   out_reg2,
  output logic [DATA_W-1:0]   out_pc,
  output logic [ADDR_W-1:0]   out_reg_write_addr,
  output logic                out_reg_write_en
`ifdef ID_EX_PERF_CNT_EN
  ,output logic [31:0]        stall_cnt
  ,output logic [31:0]        bubble_cnt
`endif
);

  localparam int unsigned PAY_W  = ALUSEL_W + ALUOP_W + 3 * DATA_W + ADDR_W + 1;
  localparam int unsigned REST_W = PAY_W - ALUSEL_W - ALUOP_W;
  localparam logic [PAY_W-1:0] RST_PAY =
    {ALUSEL_W'(ALU_SEL_NOP), ALUOP_W'(ALU_NOP), {REST_W{1'b0}}};

  logic [PAY_W-1:0] pay_in, pay_out;
  logic             valid_w;
  logic             wen_raw;

  assign pay_in = {in_alusel, in_aluop, in_reg1, in_reg2, in_pc,
                   in_reg_write_addr, in_reg_write_en};

  pipe_skid_buf #(
    .WIDTH   (PAY_W),
    .RST_VAL (RST_PAY)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (valid_w),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_alusel, out_aluop, out_reg1, out_reg2, out_pc,
          out_reg_write_addr, wen_raw} = pay_out;

  // A bubble must never write back.
  assign out_valid        = valid_w;
  assign out_reg_write_en = wen_raw & valid_w;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_w && !out_ready && (stall_cnt_q != '1)) stall_cnt_d  = stall_cnt_q + 32'd1;
    if (!valid_w && (bubble_cnt_q != '1))             bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
